// File: rtl/rr_decode_sched_if.sv
// Handshake bundle between the requesters and the decoder scheduler.
// master: requester side (req, done); slave: scheduler side (sel, sel_valid, grant, expired).
interface rr_decode_sched_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       sel_valid;
  logic [7:0] grant;
  logic       expired;

  modport master (
    output req,
    output done,
    input  sel,
    input  sel_valid,
    input  grant,
    input  expired
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output sel_valid,
    output grant,
    output expired
  );
endinterface

// File: rtl/rr_decode_sched.sv
// Round-robin scheduler sharing one 3-to-8 decoder among eight requesters.
// Ports: clk, rst_n (sync, active-low), bus (slave: req/done in; sel/sel_valid/grant/expired out).
module rr_decode_sched #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decode_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit HOLD_EN = (MAX_HOLD > 0);

  state_t            state, state_n;
  logic [2:0]        sel, sel_n;
  logic              vld, vld_n;
  logic [7:0]        gnt, gnt_n;
  logic              exp_q, exp_n;
  logic [2:0]        last, last_n;
  logic [HOLD_W-1:0] hold, hold_n;

  logic [2:0]        pick;
  logic              found;
  logic [2:0]        idx;
  logic              rel;
  logic              tmo;

  // Scan from last+1 upward with wrap; i=8 wraps back to last itself.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign rel = bus.done || !bus.req[sel];
  assign tmo = HOLD_EN && (hold == HOLD_LAST);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    vld_n   = vld;
    gnt_n   = gnt;
    exp_n   = 1'b0;
    last_n  = last;
    hold_n  = hold;
    unique case (state)
      IDLE, GAP: begin
        if (found) begin
          sel_n   = pick;
          gnt_n   = 8'(1) << pick;
          last_n  = pick;
          vld_n   = 1'b1;
          hold_n  = '0;
          state_n = GRANT;
        end else begin
          vld_n   = 1'b0;
          gnt_n   = '0;
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (rel || tmo) begin
          vld_n   = 1'b0;
          gnt_n   = '0;
          // A normal release wins over a coincident timeout.
          exp_n   = tmo && !rel;
          state_n = GAP;
        end else if (HOLD_EN) begin
          hold_n  = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      vld   <= 1'b0;
      gnt   <= '0;
      exp_q <= 1'b0;
      last  <= 3'd7;
      hold  <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      vld   <= vld_n;
      gnt   <= gnt_n;
      exp_q <= exp_n;
      last  <= last_n;
      hold  <= hold_n;
    end
  end

  assign bus.sel       = sel;
  assign bus.sel_valid = vld;
  assign bus.grant     = gnt;
  assign bus.expired   = exp_q;

endmodule
